// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit controller slice.
//   - Register word addresses on the Avalon-MM slave port.
//   - Bit positions inside the STATUS and CONTROL registers.
//   - Transmit sequencing FSM state type.
//   - Baud wrap helper shared by anything that needs the tick condition.
package uart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_DIV    = 2'd3;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVERRUN   = 3;
    localparam int STAT_LEVEL_LSB = 8;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

    // A divisor of 0 or 1 means "tick every cycle"; otherwise the counter
    // wraps on its last value, giving one tick every div cycles.
    function automatic logic baudWrap(input logic [15:0] cnt, input logic [15:0] div);
        return (div <= 16'd1) || (cnt == div - 16'd1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
// Single-clock FIFO buffering host bytes for the transmit controller.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   push_i, wdata_i write one entry (ignored when full or flushing)
//   pop_i           drop the head entry (ignored when empty or flushing)
//   flush_i         empty the FIFO in one cycle; wins over push and pop
//   rdata_o         current head entry (valid while not empty)
//   full_o, empty_o occupancy flags
//   level_o         number of stored entries, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];

    // Fullness and emptiness are judged on the registered count, so a push
    // arriving while full is refused even if a pop frees a slot this cycle.
    assign doPush = push_i && !full_o && !flush_i;
    assign doPop  = pop_i && !empty_o && !flush_i;

    // Storage array carries no reset; only entries below the count are read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
// Avalon-MM slave that queues host bytes and feeds them one at a time to the
// UART transmit core, generates the baud enable and exposes its registers.
// Ports:
//   clk, reset                     system clock, synchronous active-high reset
//   avs_address/write/writedata    register writes (DATA, STATUS, CONTROL, DIVISOR)
//   avs_read, avs_readdata         register reads, data registered one cycle later
//   core_valid, core_data          byte offered to tx_core
//   core_ready                     tx_core takes core_data this cycle
//   core_done                      tx_core finished the stop bit
//   baud_tick                      one-cycle baud enable to tx_core
//   irq                            level interrupt
// Build option: define UART_TX_IRQ_EN to include the interrupt enable flop and
// the registered irq output; without it irq is tied low and CONTROL[2] reads 0.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        core_valid,
    output logic [7:0]  core_data,
    input  logic        core_ready,
    input  logic        core_done,
    output logic        baud_tick,
    output logic        irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t   state_q, state_d;
    logic [7:0]  coreData_q, coreData_d;
    logic        enable_q;
    logic        overrun_q;
    logic [15:0] divisor_q;
    logic [15:0] baudCnt_q, baudCnt_d;
    logic [31:0] readData_q;
    logic [31:0] readMux;

    logic        wrData, wrStatus, wrCtrl, wrDiv;
    logic        flushReq;
    logic        fifoPop;
    logic [7:0]  fifoRdata;
    logic        fifoFull, fifoEmpty;
    logic [LW-1:0] fifoLevel;
    logic [8:0]  levelWide;
    logic        busy;
    logic        baudRun;
    logic        baudTick;
    logic        irqEnRead;
    logic        unusedBits;

    assign wrData   = avs_write && (avs_address == ADDR_DATA);
    assign wrStatus = avs_write && (avs_address == ADDR_STATUS);
    assign wrCtrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wrDiv    = avs_write && (avs_address == ADDR_DIV);
    assign flushReq = wrCtrl && avs_writedata[CTRL_FLUSH];

    assign busy      = (state_q != IDLE);
    assign levelWide = 9'(fifoLevel);
    assign unusedBits = ^{avs_writedata[31:16], levelWide[8]};

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wrData),
        .wdata_i (avs_writedata[7:0]),
        .pop_i   (fifoPop),
        .flush_i (flushReq),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    // Next-state logic for the hand-off to tx_core. A byte is popped only
    // from IDLE, and not in a flush cycle, so the flushed contents can never
    // leak into core_data. A byte already popped always runs to core_done.
    always_comb begin
        state_d    = state_q;
        coreData_d = coreData_q;
        fifoPop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_q && !fifoEmpty && !flushReq) begin
                    fifoPop    = 1'b1;
                    coreData_d = fifoRdata;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (core_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and the byte presented to tx_core.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            coreData_q <= '0;
        end else begin
            state_q    <= state_d;
            coreData_q <= coreData_d;
        end
    end

    assign core_valid = (state_q == LOAD);
    assign core_data  = coreData_q;

    // Baud counter only runs while the block is enabled or still finishing a
    // byte; a DIVISOR write restarts it so the new rate starts cleanly.
    always_comb begin
        baudRun  = enable_q || busy;
        baudTick = baudRun && baudWrap(baudCnt_q, divisor_q);
        if (wrDiv || !baudRun || baudTick) begin
            baudCnt_d = '0;
        end else begin
            baudCnt_d = baudCnt_q + 16'd1;
        end
    end

    assign baud_tick = baudTick;

    // Control, divisor, sticky overrun and baud counter registers. A push
    // to a full FIFO sets overrun unless the same cycle flushes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q  <= 1'b0;
            overrun_q <= 1'b0;
            divisor_q <= DIV_DEFAULT;
            baudCnt_q <= '0;
        end else begin
            baudCnt_q <= baudCnt_d;
            if (wrCtrl) begin
                enable_q <= avs_writedata[CTRL_ENABLE];
            end
            if (wrDiv) begin
                divisor_q <= avs_writedata[15:0];
            end
            if (wrStatus && avs_writedata[STAT_OVERRUN]) begin
                overrun_q <= 1'b0;
            end else if (wrData && fifoFull && !flushReq) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irqEn_q;
    logic irq_q;

    // Interrupt enable plus a registered irq: the condition is sampled from
    // the current registers, so irq follows it by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqEn_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wrCtrl) begin
                irqEn_q <= avs_writedata[CTRL_IRQ_EN];
            end
            irq_q <= irqEn_q && ((fifoEmpty && !busy) || overrun_q);
        end
    end

    assign irqEnRead = irqEn_q;
    assign irq       = irq_q;
`else
    assign irqEnRead = 1'b0;
    assign irq       = 1'b0;
`endif

    // Read mux built from the registers as they stand before any write in
    // the same cycle, which gives read-before-write on a shared address.
    always_comb begin
        readMux = '0;
        case (avs_address)
            ADDR_STATUS: begin
                readMux[STAT_EMPTY]             = fifoEmpty;
                readMux[STAT_FULL]              = fifoFull;
                readMux[STAT_BUSY]              = busy;
                readMux[STAT_OVERRUN]           = overrun_q;
                readMux[STAT_LEVEL_LSB +: 8]    = levelWide[7:0];
            end
            ADDR_CTRL: begin
                readMux[CTRL_ENABLE] = enable_q;
                readMux[CTRL_IRQ_EN] = irqEnRead;
            end
            ADDR_DIV: begin
                readMux[15:0] = divisor_q;
            end
            default: readMux = '0;
        endcase
    end

    // Read data register holds its value until the next read strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            readData_q <= '0;
        end else if (avs_read) begin
            readData_q <= readMux;
        end
    end

    assign avs_readdata = readData_q;

endmodule
